led_channel_blinker: RTL and testbench

LED_CHANNEL_BLINKER -- requirements
Module: led_channel_blinker

---
 rtl/led_pkg.sv | 14 +
 rtl/led_tick_gen.sv | 43 ++++
 rtl/led_channel_blinker.sv | 133 +++++++++++++
 tb/tb_led_channel_blinker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared mode encoding and duty-cycle constants for the LED channel blinker.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_e;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

endpackage

// File: rtl/led_tick_gen.sv
// Base tick generator: one-cycle pulse every CLK_HZ/TICK_HZ enabled cycles, combinational off the divider.
// No backpressure; en low freezes the divider so the residual count survives.
module led_tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic FPGA_CLK1_50,
  input  logic KEY0_n,
  input  logic en,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_cfg
      $error("led_tick_gen: CLK_HZ must be a multiple of TICK_HZ with a ratio of at least 2");
    end
  endgenerate

  logic [DW-1:0] div_q, div_d;
  logic          wrap;

  assign wrap = (div_q == DW'(DIV - 1));
  assign tick = en && wrap;

  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = wrap ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge KEY0_n) begin
    if (!KEY0_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/led_channel_blinker.sv
// NCH-channel LED driver (OFF/ON/BLINK/BREATHE) sharing one tick-based phase; led is registered, one cycle after inputs.
// No backpressure; en low freezes all timing. BREATHE PWM is compiled in with LED_BREATHE_EN, else mode 3 blinks.
module led_channel_blinker
  import led_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int PER_W   = 12
) (
  input  logic               FPGA_CLK1_50,
  input  logic               KEY0_n,
  input  logic               en,
  input  logic [PER_W-1:0]   period,
  input  logic [2*NCH-1:0]   mode,
  output logic [NCH-1:0]     led
);

  generate
    if (NCH < 1 || NCH > 32) begin : g_bad_nch
      $error("led_channel_blinker: NCH must be in 1..32");
    end
  endgenerate

  logic             tick;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] per_eff, per_lat;
  logic             phase_q, phase_d;
  logic             breathe_lit;
  logic [NCH-1:0]   led_q, led_d;

  led_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .FPGA_CLK1_50 (FPGA_CLK1_50),
    .KEY0_n       (KEY0_n),
    .en           (en),
    .tick         (tick)
  );

  // At count 0 no progress has been made, so the live period is taken as the latched one.
  assign per_eff = (period == '0) ? PER_W'(1) : period;
  assign per_lat = (cnt_q == '0) ? per_eff : per_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    per_d   = per_lat;
    if (tick) begin
      if (cnt_q == per_lat - PER_W'(1) || per_eff <= cnt_q) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + PER_W'(1);
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge KEY0_n) begin
    if (!KEY0_n) begin
      cnt_q   <= '0;
      per_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      phase_q <= phase_d;
    end
  end

`ifdef LED_BREATHE_EN
  logic [DUTY_W-1:0] pwm_q;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;

  // Triangle ramp: direction flips on the tick that lands on an endpoint.
  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    if (tick) begin
      duty_d = dir_q ? duty_q - DUTY_W'(1) : duty_q + DUTY_W'(1);
      if (!dir_q && duty_q == DUTY_MAX - DUTY_W'(1)) begin
        dir_d = 1'b1;
      end
      if (dir_q && duty_q == DUTY_W'(1)) begin
        dir_d = 1'b0;
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge KEY0_n) begin
    if (!KEY0_n) begin
      pwm_q  <= '0;
      duty_q <= '0;
      dir_q  <= 1'b0;
    end else begin
      pwm_q  <= pwm_q + DUTY_W'(1);
      duty_q <= duty_d;
      dir_q  <= dir_d;
    end
  end

  assign breathe_lit = (pwm_q < duty_q);
`else
  assign breathe_lit = phase_q;
`endif

  always_comb begin
    led_d = '0;
    for (int k = 0; k < NCH; k++) begin
      case (led_mode_e'(mode[2*k +: 2]))
        LED_OFF:     led_d[k] = 1'b0;
        LED_ON:      led_d[k] = 1'b1;
        LED_BLINK:   led_d[k] = phase_q;
        LED_BREATHE: led_d[k] = breathe_lit;
        default:     led_d[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge KEY0_n) begin
    if (!KEY0_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_channel_blinker.sv
// Scoreboard bench: driver pushes reference-model LED values per cycle, a negedge monitor pops and compares.
module tb_led_channel_blinker;

  localparam int NCH     = 4;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int PER_W   = 12;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic               clk    = 1'b0;
  logic               rst_n  = 1'b0;
  logic               en     = 1'b0;
  logic [PER_W-1:0]   period = '0;
  logic [2*NCH-1:0]   mode   = '0;
  logic [NCH-1:0]     led;

  always #5 clk = ~clk;

  led_channel_blinker #(
    .NCH     (NCH),
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .PER_W   (PER_W)
  ) dut (
    .FPGA_CLK1_50 (clk),
    .KEY0_n       (rst_n),
    .en           (en),
    .period       (period),
    .mode         (mode),
    .led          (led)
  );

  typedef struct {
    int             cyc;
    logic [NCH-1:0] led;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: counts in plain integers, derived from the tick/period rules.
  int m_ecyc, m_cnt, m_plat, m_phase, m_ticks, m_pwm;

  task automatic model_reset();
    m_ecyc = 0; m_cnt = 0; m_plat = 1; m_phase = 0; m_ticks = 0; m_pwm = 0;
  endtask

  function automatic logic [NCH-1:0] model_led(input logic [2*NCH-1:0] md);
    logic [NCH-1:0] r;
    int pos, duty;
    pos  = m_ticks % 510;
    duty = (pos <= 255) ? pos : 510 - pos;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      case (md[2*k +: 2])
        2'd0: r[k] = 1'b0;
        2'd1: r[k] = 1'b1;
        2'd2: r[k] = m_phase[0];
`ifdef LED_BREATHE_EN
        default: r[k] = (m_pwm < duty);
`else
        default: r[k] = (duty < 0) ? 1'b0 : m_phase[0];
`endif
      endcase
    end
    return r;
  endfunction

  task automatic model_advance(input logic e, input logic [PER_W-1:0] p);
    int  effp;
    bit  tk;
    effp = (p == 0) ? 1 : int'(p);
    tk   = e && ((m_ecyc % DIV) == DIV - 1);
    if (e) m_ecyc++;
    m_pwm = (m_pwm + 1) % 256;
    if (m_cnt == 0) m_plat = effp;
    if (tk) begin
      m_ticks++;
      if (m_cnt == m_plat - 1 || effp <= m_cnt) begin
        m_cnt   = 0;
        m_phase = 1 - m_phase;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock of stimulus; expected value refers to the LED state after the next rising edge.
  task automatic drive(input logic e, input logic [PER_W-1:0] p, input logic [2*NCH-1:0] md, input logic r);
    logic [NCH-1:0] exp;
    exp_t last;
    @(posedge clk);
    #1;
    if (rst_n && !r && sb.size() > 0 && sb[sb.size()-1].cyc == cyc) begin
      last = sb.pop_back();
      last.led = '0;
      sb.push_back(last);
    end
    rst_n = r; en = e; period = p; mode = md;
    if (!r) begin
      #1;
      check("async_reset_led", 32'(led), 32'd0);
      model_reset();
      exp = '0;
    end else begin
      exp = model_led(md);
      model_advance(e, p);
    end
    sb.push_back('{cyc + 1, exp});
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check("led_scoreboard", 32'(led), 32'(e.led));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of stimulus, expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic             c_en;
    logic [PER_W-1:0] c_per;
    logic [2*NCH-1:0] c_mode;
    model_reset();

    // Reset state, then the reference blink sequence with fixed checkpoints.
    drive(1'b0, 12'd3, 8'hAA, 1'b0);
    drive(1'b0, 12'd3, 8'hAA, 1'b0);
    check("reset_led", 32'(led), 32'd0);
    drive(1'b1, 12'd3, 8'hAA, 1'b1);
    fork
      begin
        for (int i = 0; i < 64; i++) drive(1'b1, 12'd3, 8'hAA, 1'b1);
      end
      begin
        repeat (30) @(posedge clk);
        @(negedge clk) check("blink_cycle30", 32'(led), 32'h0);
        @(posedge clk);
        @(negedge clk) check("blink_cycle31", 32'(led), 32'hF);
        repeat (29) @(posedge clk);
        @(negedge clk) check("blink_cycle60", 32'(led), 32'hF);
        @(posedge clk);
        @(negedge clk) check("blink_cycle61", 32'(led), 32'h0);
      end
    join

    // Mixed modes, then reset mid-period while channel 1 is lit.
    for (int i = 0; i < 80; i++) drive(1'b1, 12'd3, 8'h24, 1'b1);
    drive(1'b1, 12'd3, 8'h24, 1'b0);
    drive(1'b1, 12'd3, 8'h24, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 12'd3, 8'hAA, 1'b1);

    // Period 0 with an enable freeze in the middle.
    for (int i = 0; i < 35; i++) drive(1'b1, 12'd0, 8'hAA, 1'b1);
    for (int i = 0; i < 25; i++) drive(1'b0, 12'd0, 8'hAA, 1'b1);
    for (int i = 0; i < 40; i++) drive(1'b1, 12'd0, 8'hAA, 1'b1);

    // Period change 3 -> 5 while the tick count is 1.
    drive(1'b1, 12'd3, 8'hAA, 1'b0);
    for (int i = 0; i < 100 && m_cnt != 1; i++) drive(1'b1, 12'd3, 8'hAA, 1'b1);
    for (int i = 0; i < 140; i++) drive(1'b1, 12'd5, 8'hAA, 1'b1);
    // Shrink below the current count: wraps on the next tick.
    for (int i = 0; i < 100 && m_cnt != 4; i++) drive(1'b1, 12'd5, 8'hAA, 1'b1);
    for (int i = 0; i < 60; i++) drive(1'b1, 12'd2, 8'hAA, 1'b1);

    // Randomised run.
    c_en = 1'b1; c_per = 12'd2; c_mode = 8'hE4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) c_per = PER_W'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) c_mode = 8'($urandom);
      if ($urandom_range(0, 29) == 0) c_en = ~c_en;
      else if (!c_en && $urandom_range(0, 3) == 0) c_en = 1'b1;
      if ($urandom_range(0, 799) == 0) begin
        repeat ($urandom_range(1, 3)) drive(c_en, c_per, c_mode, 1'b0);
      end
      drive(c_en, c_per, c_mode, 1'b1);
    end

`ifdef LED_BREATHE_EN
    drive(1'b1, 12'd3, 8'hFF, 1'b0);
    for (int i = 0; i < 5300; i++) drive(1'b1, 12'd3, 8'hFF, 1'b1);
`else
    drive(1'b1, 12'd3, 8'hFF, 1'b0);
    for (int i = 0; i < 70; i++) drive(1'b1, 12'd3, 8'hFF, 1'b1);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
